// File: rtl/jtvigil_palload.sv
// ---------------------------------------------------------------------------
// jtvigil_palload
//   Copies a run of packed RGB555 entries from a source memory into the
//   palette RAM. Each entry is written as three byte writes: R, G and B,
//   selected by address bits [9:8]. A CPU write to the palette RAM always
//   takes priority. When that happens the loader stalls in its current
//   write state.
//
//   Optional build macro: JTVIGIL_PALLOAD_FILL_EN
//     Enables fill mode. With fill=1 at start, a single latched colour is
//     written and the source is never read.
//
// Ports
//   rst, clk        async active-high reset, clock
//   start           load request (only honoured in IDLE)
//   bank            palette half, 0 = OBJ, 1 = SCR (latched)
//   first_idx       first colour index (latched)
//   count           number of entries, clamped to 256 (latched)
//   src_addr/src_cs source read address (entry offset) and request
//   src_ok/src_data source data valid and packed entry
//   cpu_we          CPU owns the palette RAM this cycle
//   fill/fill_data  fill mode request and colour
//   pal_addr/pal_dout/pal_we  palette RAM write port
//   busy            load in progress
//   done            one-cycle completion pulse
// ---------------------------------------------------------------------------
module jtvigil_palload (
  input  logic        rst,
  input  logic        clk,
  input  logic        start,
  input  logic        bank,
  input  logic [7:0]  first_idx,
  input  logic [8:0]  count,
  output logic [8:0]  src_addr,
  output logic        src_cs,
  input  logic        src_ok,
  input  logic [15:0] src_data,
  input  logic        cpu_we,
  input  logic        fill,
  input  logic [14:0] fill_data,
  output logic [10:0] pal_addr,
  output logic [7:0]  pal_dout,
  output logic        pal_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WR_R   = 3'd2,
    WR_G   = 3'd3,
    WR_B   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t      st, st_nx;
  logic        bank_l;
  logic [7:0]  idx0_l;
  logic [8:0]  cnt_l;
  logic [8:0]  n;
  logic [14:0] data_l;
  logic        fill_l;

  logic        fill_req;
  logic [8:0]  cnt_clamp;
  logic        wr_st;
  logic [1:0]  comp;
  logic [7:0]  idx;
  logic [4:0]  comp_val;
  logic [8:0]  n_inc;

`ifdef JTVIGIL_PALLOAD_FILL_EN
  assign fill_req = fill;
`else
  // Fill inputs are kept on the port list but have no effect in this build.
  logic unused_fill;
  assign unused_fill = fill ^ (^fill_data);
  assign fill_req    = 1'b0;
`endif

  assign cnt_clamp = (count > 9'd256) ? 9'd256 : count;
  assign n_inc     = n + 9'd1;

  // Only the low byte of first_idx + n matters, so the index wraps
  // within the latched bank and never carries into comp/bank bits.
  assign idx = idx0_l + n[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      bank_l <= 1'b0;
      idx0_l <= 8'd0;
      cnt_l  <= 9'd0;
      n      <= 9'd0;
      data_l <= 15'd0;
      fill_l <= 1'b0;
    end else begin
      st <= st_nx;
      if (st == IDLE && start) begin
        bank_l <= bank;
        idx0_l <= first_idx;
        cnt_l  <= cnt_clamp;
        n      <= 9'd0;
        fill_l <= fill_req;
        if (fill_req) data_l <= fill_data;
      end
      if (st == FETCH && src_ok && n != cnt_l)
        data_l <= src_data[14:0];
      if (st == WR_B && !cpu_we)
        n <= n_inc;
    end
  end

  // A start always passes through FETCH except for non-empty fill loads.
  // FETCH with n == count can only happen for count == 0; it then goes
  // straight to FINISH without requesting the source.
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:
        if (start) st_nx = (fill_req && cnt_clamp != 9'd0) ? WR_R : FETCH;
      FETCH:
        if (n == cnt_l)  st_nx = FINISH;
        else if (src_ok) st_nx = WR_R;
      WR_R:
        if (!cpu_we) st_nx = WR_G;
      WR_G:
        if (!cpu_we) st_nx = WR_B;
      WR_B:
        if (!cpu_we) begin
          if (n_inc == cnt_l) st_nx = FINISH;
          else                st_nx = fill_l ? WR_R : FETCH;
        end
      FINISH:
        st_nx = IDLE;
      default:
        st_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_st    = 1'b0;
    comp     = 2'd0;
    comp_val = 5'd0;
    unique case (st)
      WR_R: begin wr_st = 1'b1; comp = 2'd0; comp_val = data_l[4:0];   end
      WR_G: begin wr_st = 1'b1; comp = 2'd1; comp_val = data_l[9:5];   end
      WR_B: begin wr_st = 1'b1; comp = 2'd2; comp_val = data_l[14:10]; end
      default: ;
    endcase
  end

  assign pal_we   = wr_st && !cpu_we;
  assign pal_addr = wr_st ? {bank_l, comp, idx} : 11'd0;
  assign pal_dout = wr_st ? {3'b000, comp_val} : 8'd0;
  assign src_cs   = (st == FETCH) && (n != cnt_l);
  assign src_addr = n;
  assign busy     = (st == FETCH) || wr_st;
  assign done     = (st == FINISH);

endmodule

// File: tb/tb_jtvigil_palload.sv
// ---------------------------------------------------------------------------
// tb_jtvigil_palload
//   Directed bench for jtvigil_palload. A table of single-entry loads is
//   applied in a loop, followed by hand-written sequences: index wrap,
//   CPU stall, slow source, zero and oversized counts, mid-load reset and
//   fill mode (or its absence, depending on JTVIGIL_PALLOAD_FILL_EN).
// ---------------------------------------------------------------------------
module tb_jtvigil_palload;

  logic        rst, clk, start, bank, src_cs, src_ok, cpu_we, fill;
  logic        pal_we, busy, done;
  logic [7:0]  first_idx, pal_dout;
  logic [8:0]  count, src_addr;
  logic [15:0] src_data;
  logic [14:0] fill_data;
  logic [10:0] pal_addr;

  jtvigil_palload dut (
    .rst(rst), .clk(clk), .start(start), .bank(bank), .first_idx(first_idx),
    .count(count), .src_addr(src_addr), .src_cs(src_cs), .src_ok(src_ok),
    .src_data(src_data), .cpu_we(cpu_we), .fill(fill), .fill_data(fill_data),
    .pal_addr(pal_addr), .pal_dout(pal_dout), .pal_we(pal_we), .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source model: entry n holds src_base + n; src_ok after src_wait cycles.
  logic [15:0] src_base;
  int          src_wait;
  int          cs_age;
  always @(posedge clk) cs_age <= src_cs ? cs_age + 1 : 0;
  assign src_ok   = src_cs && (cs_age >= src_wait);
  assign src_data = src_base + {7'd0, src_addr};

  // Output monitor, sampled on the falling edge.
  int          negc, done_cnt, done_at, cs_cnt;
  logic [10:0] wa[$];
  logic [7:0]  wd[$];
  int          wt[$];
  always @(negedge clk) begin
    negc++;
    if (pal_we) begin
      wa.push_back(pal_addr);
      wd.push_back(pal_dout);
      wt.push_back(negc);
    end
    if (done) begin
      done_cnt++;
      done_at = negc;
    end
    if (src_cs) cs_cnt++;
  end

  int tests, fails;
  int start_neg, done0, cs0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_load(input logic b, input logic [7:0] idx, input logic [8:0] cnt,
                            input logic f, input logic [14:0] fd);
    @(posedge clk); #1;
    bank = b; first_idx = idx; count = cnt; fill = f; fill_data = fd;
    start = 1'b1;
    wa.delete(); wd.delete(); wt.delete();
    start_neg = negc + 1;
    done0 = done_cnt;
    cs0 = cs_cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input int exp_lat);
    int k;
    k = 0;
    while (done_cnt == done0 && k < budget) begin
      @(posedge clk); k++;
    end
    chk({name, "_done_seen"}, int'(done_cnt != done0), 1);
    chk({name, "_done_lat"}, done_at - start_neg, exp_lat);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_done_pulses"}, done_cnt - done0, 1);
    chk({name, "_busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic        b;
    logic [7:0]  idx;
    logic [15:0] base;
    logic [10:0] ar, ag, ab;
    logic [7:0]  dr, dg, db;
  } vec_t;

  initial begin
    vec_t        vt[4];
    logic [10:0] wrap_a[9];
    logic [7:0]  wrap_d[9];

    vt[0] = '{1'b1, 8'h10, 16'h7FFF, 11'h410, 11'h510, 11'h610, 8'h1F, 8'h1F, 8'h1F};
    vt[1] = '{1'b0, 8'h00, 16'h03E0, 11'h000, 11'h100, 11'h200, 8'h00, 8'h1F, 8'h00};
    vt[2] = '{1'b0, 8'h80, 16'h8421, 11'h080, 11'h180, 11'h280, 8'h01, 8'h01, 8'h01};
    vt[3] = '{1'b1, 8'hFF, 16'h7C00, 11'h4FF, 11'h5FF, 11'h6FF, 8'h00, 8'h00, 8'h1F};

    wrap_a = '{11'h0FE, 11'h1FE, 11'h2FE, 11'h0FF, 11'h1FF, 11'h2FF, 11'h000, 11'h100, 11'h200};
    wrap_d = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};

    tests = 0; fails = 0;
    negc = 0; done_cnt = 0; done_at = 0; cs_cnt = 0;
    rst = 1'b1; start = 1'b0; bank = 1'b0; first_idx = 8'd0; count = 9'd0;
    cpu_we = 1'b0; fill = 1'b0; fill_data = 15'd0; src_base = 16'd0; src_wait = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pal_we", int'(pal_we), 0);
    chk("rst_src_cs", int'(src_cs), 0);
    chk("rst_pal_addr", int'(pal_addr), 0);
    chk("rst_pal_dout", int'(pal_dout), 0);
    chk("rst_src_addr", int'(src_addr), 0);
    rst = 1'b0;

    // Table of single-entry loads with immediate source data.
    for (int i = 0; i < 4; i++) begin
      src_base = vt[i].base;
      start_load(vt[i].b, vt[i].idx, 9'd1, 1'b0, 15'd0);
      chk($sformatf("v%0d_busy", i), int'(busy), 1);
      wait_done($sformatf("v%0d", i), 50, 5);
      chk($sformatf("v%0d_nwr", i), wa.size(), 3);
      if (wa.size() == 3) begin
        chk($sformatf("v%0d_ar", i), int'(wa[0]), int'(vt[i].ar));
        chk($sformatf("v%0d_ag", i), int'(wa[1]), int'(vt[i].ag));
        chk($sformatf("v%0d_ab", i), int'(wa[2]), int'(vt[i].ab));
        chk($sformatf("v%0d_dr", i), int'(wd[0]), int'(vt[i].dr));
        chk($sformatf("v%0d_dg", i), int'(wd[1]), int'(vt[i].dg));
        chk($sformatf("v%0d_db", i), int'(wd[2]), int'(vt[i].db));
        chk($sformatf("v%0d_tr", i), wt[0] - start_neg, 2);
      end
    end

    // Index wrap inside bank 0; a stray start mid-load must be ignored.
    src_base = 16'h0000;
    start_load(1'b0, 8'hFE, 9'd3, 1'b0, 15'd0);
    repeat (3) @(posedge clk);
    #1;
    bank = 1'b1; first_idx = 8'h00; count = 9'd1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("wrap", 80, 13);
    chk("wrap_nwr", wa.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < wa.size()) begin
        chk($sformatf("wrap_a%0d", i), int'(wa[i]), int'(wrap_a[i]));
        chk($sformatf("wrap_d%0d", i), int'(wd[i]), int'(wrap_d[i]));
      end

    // CPU holds the RAM for two cycles while WR_G is active.
    src_base = 16'h1234;
    start_load(1'b0, 8'h40, 9'd1, 1'b0, 15'd0);
    repeat (2) @(posedge clk);
    #1;
    cpu_we = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cpu_we = 1'b0;
    wait_done("stall", 50, 7);
    chk("stall_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("stall_a0", int'(wa[0]), 11'h040);
      chk("stall_a1", int'(wa[1]), 11'h140);
      chk("stall_a2", int'(wa[2]), 11'h240);
      chk("stall_d0", int'(wd[0]), 8'h14);
      chk("stall_d1", int'(wd[1]), 8'h11);
      chk("stall_d2", int'(wd[2]), 8'h04);
      chk("stall_tg", wt[1] - start_neg, 5);
    end

    // Slow source: src_ok two cycles after the request rises.
    src_wait = 2;
    src_base = 16'h0C63;
    start_load(1'b1, 8'h33, 9'd1, 1'b0, 15'd0);
    wait_done("slow", 50, 7);
    chk("slow_nwr", wa.size(), 3);
    if (wa.size() == 3) chk("slow_dg", int'(wd[1]), 8'h03);
    src_wait = 0;

    // Zero count: no writes, no source access.
    start_load(1'b0, 8'h00, 9'd0, 1'b0, 15'd0);
    wait_done("cnt0", 20, 2);
    chk("cnt0_nwr", wa.size(), 0);
    chk("cnt0_cs", cs_cnt - cs0, 0);

    // Oversized count is clamped to 256 entries.
    src_base = 16'h0000;
    start_load(1'b0, 8'h00, 9'd300, 1'b0, 15'd0);
    wait_done("cnt300", 1500, 1025);
    chk("cnt300_nwr", wa.size(), 768);
    if (wa.size() == 768) chk("cnt300_last_a", int'(wa[767]), 11'h2FF);

    // Reset during WR_G of entry 5.
    start_load(1'b0, 8'h00, 9'd8, 1'b0, 15'd0);
    repeat (22) @(posedge clk);
    #1;
    chk("rstmid_we_before", int'(pal_we), 1);
    chk("rstmid_addr_before", int'(pal_addr), 11'h105);
    rst = 1'b1;
    #1;
    chk("rstmid_we", int'(pal_we), 0);
    chk("rstmid_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_nwr", wa.size(), 16);
    chk("rstmid_done", done_cnt - done0, 0);
    rst = 1'b0;
    src_base = 16'h0C63;
    start_load(1'b1, 8'h22, 9'd1, 1'b0, 15'd0);
    wait_done("post_rst", 50, 5);
    chk("post_rst_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("post_rst_a0", int'(wa[0]), 11'h422);
      chk("post_rst_a2", int'(wa[2]), 11'h622);
      chk("post_rst_d1", int'(wd[1]), 8'h03);
    end

`ifdef JTVIGIL_PALLOAD_FILL_EN
    src_base = 16'h7FFF;
    start_load(1'b0, 8'h20, 9'd4, 1'b1, 15'h03E0);
    wait_done("fill", 80, 13);
    chk("fill_nwr", wa.size(), 12);
    chk("fill_cs", cs_cnt - cs0, 0);
    for (int i = 0; i < 12; i++)
      if (i < wa.size())
        chk($sformatf("fill_d%0d", i), int'(wd[i]), (i % 3 == 1) ? 8'h1F : 8'h00);
`else
    // Without fill support the request is ignored and the source is read.
    src_base = 16'h7FFF;
    start_load(1'b0, 8'h20, 9'd1, 1'b1, 15'h03E0);
    wait_done("nofill", 50, 5);
    chk("nofill_cs", cs_cnt - cs0, 1);
    if (wa.size() == 3) chk("nofill_dr", int'(wd[0]), 8'h1F);
    else chk("nofill_nwr", wa.size(), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
